frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Controls the FFT-output stream ahead of the power/mel stages. Sequences one utterance of NUM_FRAMES frames of FFT_N bins each.
- Tags every beat with bin and frame indices and forwards only the non-redundant bins 0..KEEP_BINS-1.
- Raises done after the last bin of the last frame.
- Replaces free-running beat counting with an explicit start/run/done controller.

Parameters:
- I_BW, 14, input real/imag width (two's complement)
- O_BW, 14, output real/imag width
- FFT_N, 256, bins per frame
- KEEP_BINS, 129, bins forwarded per frame (FFT_N/2+1); must be <= FFT_N
- NUM_FRAMES, 59, frames per utterance (59*256 = 15104 beats)

Ports:
- clk, input, 1, clock, rising edge
- rst, input, 1, asynchronous active-low reset
- start, input, 1, single-cycle pulse; clears counters and enters RUN
- di_en, input, 1, input beat valid
- di_re, input, I_BW, input real part
- di_im, input, I_BW, input imaginary part
- do_en, output, 1, output beat valid (registered)
- do_re, output, O_BW, output real part
- do_im, output, O_BW, output imaginary part
- bin_idx, output, $clog2(FFT_N), bin index of the current output beat
- frame_idx, output, $clog2(NUM_FRAMES), frame index of the current output beat
- frame_first, output, 1, high with the output beat carrying bin 0
- frame_last, output, 1, high with the output beat carrying bin KEEP_BINS-1
- busy, output, 1, high in RUN
- done, output, 1, high in DONE
- err, output, 1, sticky sequencing error (see Optional Feature)

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE.
  - All outputs 0, including do_re, do_im, bin_idx, frame_idx, err.
  - Internal bin/frame counters 0.
- States: IDLE, RUN, DONE. busy is 1 only in RUN; done is 1 only in DONE.
- IDLE:
  - di_en beats are ignored; do_en stays 0.
  - start -> RUN, counters cleared.
- RUN: each di_en beat uses the internal bin counter b and frame counter f.
  - If b < KEEP_BINS: next cycle do_en=1, with do_re/do_im, bin_idx=b, frame_idx=f, frame_first=(b==0), frame_last=(b==KEEP_BINS-1).
  - Otherwise the beat is dropped: next cycle do_en=0, frame_first=0, frame_last=0.
  - Latency is exactly 1 cycle. Gaps in di_en are allowed; counters hold during gaps.
  - b increments and wraps from FFT_N-1 to 0; at the wrap f increments.
  - The beat with b==FFT_N-1 and f==NUM_FRAMES-1 is consumed. The state moves to DONE on the same edge and done=1 from the next cycle.
- DONE:
  - done is held. Beats are ignored.
  - start -> RUN with counters cleared; done falls on the same edge.
- start in RUN aborts and restarts: counters go to 0 and state stays RUN. A di_en in the same cycle is dropped (start wins).
- start and di_en together in IDLE or DONE: start is taken and the beat is dropped.
- do_re/do_im update only on forwarded beats and hold their value otherwise. bin_idx and frame_idx also hold.
- do_en, frame_first and frame_last are single-cycle pulses per beat.
- Width rule:
  - O_BW >= I_BW: sign-extend.
  - O_BW < I_BW: keep the MSBs di[I_BW-1 -: O_BW] (truncate, no rounding).
- Reset mid-RUN: immediate return to the reset values; a pending output beat is lost.

Optional Feature:
- Macro SEQ_ERR_EN.
- Defined:
  - err is set (sticky) when di_en=1 while the state is IDLE or DONE and start=0.
  - err also sets if a start arrives in RUN while b != 0 (partial-frame abort).
  - Cleared only by rst or by a start that is accepted from IDLE or DONE.
- Undefined: err is tied to 0 and no error logic is synthesised; the port list is unchanged.

Decomposition:
- Package log_mel_pkg holds:
  - Default constants FFT_N_DEF=256, KEEP_BINS_DEF=129, NUM_FRAMES_DEF=59.
  - Enum seq_state_t {IDLE, RUN, DONE}.
  - Derived width localparams BIN_W and FRM_W.
- One sub-module, frame_bin_counter: nested bin/frame counter with clr, inc, bin, frame, wrap and last outputs. The FSM and output register stay in frame_sequencer.

Test Plan:
- Reset then a full run: start, then 15104 contiguous beats with di_re=bin, di_im=-bin.
  - Exactly 59*129=7611 do_en pulses.
  - Each frame shows frame_first at bin 0 and frame_last at bin 128.
  - done=1 one cycle after beat 15104; busy=0 in the same cycle.
- Beats 129..255 of frame 0 arrive -> no do_en; the next forwarded beat is bin 0, frame 1.
- Random di_en gaps (50% duty) over 2 frames -> same indices/data as the contiguous case, each output 1 cycle after its input beat.
- Mid-frame restart: start at bin 40 of frame 3 with di_en=1 -> that beat dropped; the next beat outputs bin 0, frame 0. With SEQ_ERR_EN, err=1.
- Beat in IDLE with di_re=14'h1FFF -> do_en stays 0 and do_re stays 0. With SEQ_ERR_EN err=1, cleared by the next start.
- Width check, I_BW=14, O_BW=10, di_re=14'h2ABC -> do_re=10'h2AB.
- Async reset asserted mid-RUN between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/log_mel_pkg.sv
// Shared constants, state encoding and width helpers for the log-mel front end.
package log_mel_pkg;

    localparam int FFT_N_DEF      = 256;
    localparam int KEEP_BINS_DEF  = 129;
    localparam int NUM_FRAMES_DEF = 59;

    localparam int BIN_W = $clog2(FFT_N_DEF);
    localparam int FRM_W = $clog2(NUM_FRAMES_DEF);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/frame_bin_counter.sv
// Nested bin/frame counter: bin runs 0..FFT_N-1, frame advances on each bin wrap.
module frame_bin_counter
    import log_mel_pkg::*;
#(
    parameter int FFT_N      = FFT_N_DEF,
    parameter int NUM_FRAMES = NUM_FRAMES_DEF,
    localparam int BW        = clog2_min1(FFT_N),
    localparam int FW        = clog2_min1(NUM_FRAMES)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [BW-1:0] o_bin,
    output logic [FW-1:0] o_frame,
    output logic          o_wrap,
    output logic          o_last
);

    localparam logic [BW-1:0] BIN_MAX = BW'(FFT_N - 1);
    localparam logic [FW-1:0] FRM_MAX = FW'(NUM_FRAMES - 1);

    logic [BW-1:0] r_bin;
    logic [FW-1:0] r_frame;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bin   <= '0;
            r_frame <= '0;
        end else if (i_clr) begin
            r_bin   <= '0;
            r_frame <= '0;
        end else if (i_inc) begin
            if (r_bin == BIN_MAX) begin
                r_bin   <= '0;
                r_frame <= (r_frame == FRM_MAX) ? '0 : r_frame + 1'b1;
            end else begin
                r_bin <= r_bin + 1'b1;
            end
        end
    end

    // Wrap/last are level flags on the current count, qualified by the caller.
    assign o_bin   = r_bin;
    assign o_frame = r_frame;
    assign o_wrap  = (r_bin == BIN_MAX);
    assign o_last  = (r_frame == FRM_MAX);

endmodule

// File: rtl/frame_sequencer.sv
// Start/run/done sequencer for one utterance of FFT frames; forwards bins 0..KEEP_BINS-1.
// Optional sticky sequencing error flag enabled by defining SEQ_ERR_EN.
module frame_sequencer
    import log_mel_pkg::*;
#(
    parameter int I_BW       = 14,
    parameter int O_BW       = 14,
    parameter int FFT_N      = FFT_N_DEF,
    parameter int KEEP_BINS  = KEEP_BINS_DEF,
    parameter int NUM_FRAMES = NUM_FRAMES_DEF,
    localparam int BW        = clog2_min1(FFT_N),
    localparam int FW        = clog2_min1(NUM_FRAMES)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_di_en,
    input  logic [I_BW-1:0] i_di_re,
    input  logic [I_BW-1:0] i_di_im,
    output logic            o_do_en,
    output logic [O_BW-1:0] o_do_re,
    output logic [O_BW-1:0] o_do_im,
    output logic [BW-1:0]   o_bin_idx,
    output logic [FW-1:0]   o_frame_idx,
    output logic            o_frame_first,
    output logic            o_frame_last,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    localparam logic [BW:0]   KEEP_L    = (BW + 1)'(KEEP_BINS);
    localparam logic [BW-1:0] KEEP_LAST = BW'(KEEP_BINS - 1);

    seq_state_t r_state;
    seq_state_t w_state_nxt;

    logic            w_cnt_clr;
    logic            w_cnt_inc;
    logic            w_fwd;
    logic            w_keep;
    logic            w_wrap;
    logic            w_last;
    logic [BW-1:0]   w_bin;
    logic [FW-1:0]   w_frame;
    logic [O_BW-1:0] w_re;
    logic [O_BW-1:0] w_im;

    logic            r_do_en;
    logic [O_BW-1:0] r_do_re;
    logic [O_BW-1:0] r_do_im;
    logic [BW-1:0]   r_bin_idx;
    logic [FW-1:0]   r_frame_idx;
    logic            r_frame_first;
    logic            r_frame_last;

    frame_bin_counter #(
        .FFT_N      (FFT_N),
        .NUM_FRAMES (NUM_FRAMES)
    ) u_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_bin   (w_bin),
        .o_frame (w_frame),
        .o_wrap  (w_wrap),
        .o_last  (w_last)
    );

    // Widen by sign extension, or narrow by keeping the MSBs without rounding.
    generate
        if (O_BW >= I_BW) begin : g_widen
            assign w_re = O_BW'(signed'(i_di_re));
            assign w_im = O_BW'(signed'(i_di_im));
        end else begin : g_narrow
            assign w_re = i_di_re[I_BW-1 -: O_BW];
            assign w_im = i_di_im[I_BW-1 -: O_BW];
        end
    endgenerate

    assign w_keep = ({1'b0, w_bin} < KEEP_L);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // start always wins over a coincident beat, in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_fwd       = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_state_nxt = RUN;
                    w_cnt_clr   = 1'b1;
                end
            end
            RUN: begin
                if (i_start) begin
                    w_cnt_clr = 1'b1;
                end else if (i_di_en) begin
                    w_cnt_inc = 1'b1;
                    w_fwd     = w_keep;
                    if (w_wrap && w_last) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_do_en       <= 1'b0;
            r_do_re       <= '0;
            r_do_im       <= '0;
            r_bin_idx     <= '0;
            r_frame_idx   <= '0;
            r_frame_first <= 1'b0;
            r_frame_last  <= 1'b0;
        end else begin
            r_do_en       <= w_fwd;
            r_frame_first <= w_fwd && (w_bin == '0);
            r_frame_last  <= w_fwd && (w_bin == KEEP_LAST);
            if (w_fwd) begin
                r_do_re     <= w_re;
                r_do_im     <= w_im;
                r_bin_idx   <= w_bin;
                r_frame_idx <= w_frame;
            end
        end
    end

`ifdef SEQ_ERR_EN
    logic r_err;
    logic w_err_set;
    logic w_err_clr;

    // Stray beats outside RUN, or an abort that cuts a frame short.
    assign w_err_clr = i_start && (r_state != RUN);
    assign w_err_set = ((r_state != RUN) && i_di_en && !i_start) ||
                       ((r_state == RUN) && i_start && (w_bin != '0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_clr) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_do_en       = r_do_en;
    assign o_do_re       = r_do_re;
    assign o_do_im       = r_do_im;
    assign o_bin_idx     = r_bin_idx;
    assign o_frame_idx   = r_frame_idx;
    assign o_frame_first = r_frame_first;
    assign o_frame_last  = r_frame_last;
    assign o_busy        = (r_state == RUN);
    assign o_done        = (r_state == DONE);

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: stimulus pushes expected beats, a monitor pops and compares.
module tb_frame_sequencer;

    localparam int I_BW = 14;
    localparam int KEEP = 129;
    localparam int FFTN = 256;
    localparam int NFRM = 59;
`ifdef SEQ_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic di_en;
    logic [13:0] di_re;
    logic [13:0] di_im;

    logic        do_en;
    logic [13:0] do_re;
    logic [13:0] do_im;
    logic [7:0]  bin_idx;
    logic [5:0]  frame_idx;
    logic        frame_first;
    logic        frame_last;
    logic        busy;
    logic        done;
    logic        err;

    logic        n_do_en;
    logic [9:0]  n_do_re;
    logic [9:0]  n_do_im;
    logic [7:0]  n_bin_idx;
    logic [5:0]  n_frame_idx;
    logic        n_first;
    logic        n_last;
    logic        n_busy;
    logic        n_done;
    logic        n_err;

    always #5 clk = ~clk;

    frame_sequencer #(
        .I_BW(14), .O_BW(14), .FFT_N(FFTN), .KEEP_BINS(KEEP), .NUM_FRAMES(NFRM)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_di_en(di_en),
        .i_di_re(di_re), .i_di_im(di_im),
        .o_do_en(do_en), .o_do_re(do_re), .o_do_im(do_im),
        .o_bin_idx(bin_idx), .o_frame_idx(frame_idx),
        .o_frame_first(frame_first), .o_frame_last(frame_last),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    frame_sequencer #(
        .I_BW(14), .O_BW(10), .FFT_N(FFTN), .KEEP_BINS(KEEP), .NUM_FRAMES(NFRM)
    ) dutNarrow (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_di_en(di_en),
        .i_di_re(di_re), .i_di_im(di_im),
        .o_do_en(n_do_en), .o_do_re(n_do_re), .o_do_im(n_do_im),
        .o_bin_idx(n_bin_idx), .o_frame_idx(n_frame_idx),
        .o_frame_first(n_first), .o_frame_last(n_last),
        .o_busy(n_busy), .o_done(n_done), .o_err(n_err)
    );

    typedef struct packed {
        logic [13:0] re;
        logic [13:0] im;
        logic [7:0]  bin;
        logic [5:0]  frm;
        logic        first;
        logic        last;
    } beat_t;

    beat_t       expQ[$];
    int unsigned cycQ[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          nFwd = 0;
    beat_t       monGot;
    beat_t       monExp;
    int unsigned monCyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented beat must match the oldest expected beat and its cycle.
    always @(negedge clk) begin
        if (rst_n && do_en) begin
            nFwd++;
            checks++;
            monGot = '{re: do_re, im: do_im, bin: bin_idx, frm: frame_idx,
                       first: frame_first, last: frame_last};
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_beat got bin=%0d frame=%0d re=%h required no beat",
                         bin_idx, frame_idx, do_re);
            end else begin
                monExp = expQ.pop_front();
                monCyc = cycQ.pop_front();
                if (monGot !== monExp || cyc != monCyc) begin
                    failures++;
                    $display("[TB] FAIL beat got re=%h im=%h bin=%0d frame=%0d first=%b last=%b cyc=%0d required re=%h im=%h bin=%0d frame=%0d first=%b last=%b cyc=%0d",
                             monGot.re, monGot.im, monGot.bin, monGot.frm, monGot.first, monGot.last, cyc,
                             monExp.re, monExp.im, monExp.bin, monExp.frm, monExp.first, monExp.last, monCyc);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic st, input logic en, input logic [13:0] re, input logic [13:0] im);
        @(posedge clk);
        #1;
        start = st;
        di_en = en;
        di_re = re;
        di_im = im;
    endtask

    task automatic expectBeat(input logic [13:0] re, input logic [13:0] im, input int b, input int f);
        beat_t e;
        e.re    = re;
        e.im    = im;
        e.bin   = 8'(b);
        e.frm   = 6'(f);
        e.first = (b == 0);
        e.last  = (b == KEEP - 1);
        expQ.push_back(e);
        cycQ.push_back(cyc + 1);
    endtask

    task automatic sendBeat(input int b, input int f);
        applyStimulus(1'b0, 1'b1, 14'(b), 14'(-b));
        if (b < KEEP) expectBeat(14'(b), 14'(-b), b, f);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired got=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;
        #12;
        checkOutput("rst_do_en", do_en, 0);
        checkOutput("rst_do_re", do_re, 0);
        checkOutput("rst_bin_idx", bin_idx, 0);
        checkOutput("rst_frame_idx", frame_idx, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stray beat while idle.
        applyStimulus(1'b0, 1'b1, 14'h1FFF, 14'h0000);
        applyStimulus(1'b0, 1'b0, 14'h0, 14'h0);
        @(negedge clk);
        checkOutput("idle_do_en", do_en, 0);
        checkOutput("idle_do_re", do_re, 0);
        checkOutput("idle_err", err, ERR_ON);

        // Full contiguous utterance.
        nFwd = 0;
        applyStimulus(1'b1, 1'b0, 14'h0, 14'h0);
        applyStimulus(1'b0, 1'b0, 14'h0, 14'h0);
        checkOutput("run_busy", busy, 1);
        checkOutput("run_err_cleared", err, 0);
        for (int f = 0; f < NFRM; f++)
            for (int b = 0; b < FFTN; b++)
                sendBeat(b, f);
        applyStimulus(1'b0, 1'b0, 14'h0, 14'h0);
        checkOutput("end_done", done, 1);
        checkOutput("end_busy", busy, 0);
        @(negedge clk);
        #1;
        checkOutput("fwd_count", nFwd, NFRM * KEEP);

        // Stray beat in DONE.
        applyStimulus(1'b0, 1'b1, 14'h0005, 14'h0005);
        applyStimulus(1'b0, 1'b0, 14'h0, 14'h0);
        @(negedge clk);
        checkOutput("done_held", done, 1);
        checkOutput("done_err", err, ERR_ON);

        // Gapped frames 0..1, then contiguous up to bin 39 of frame 3.
        applyStimulus(1'b1, 1'b0, 14'h0, 14'h0);
        for (int i = 0; i < 3 * FFTN + 40; i++) begin
            if (i < 2 * FFTN)
                for (int g = 0; g < 3 && $urandom_range(1) == 1; g++)
                    applyStimulus(1'b0, 1'b0, 14'h0, 14'h0);
            sendBeat(i % FFTN, i / FFTN);
        end
        applyStimulus(1'b0, 1'b0, 14'h0, 14'h0);
        checkOutput("pre_restart_err", err, 0);
        checkOutput("pre_restart_busy", busy, 1);

        // Restart at bin 40 with a coincident beat; the beat must vanish.
        applyStimulus(1'b1, 1'b1, 14'h0777, 14'h0777);
        applyStimulus(1'b0, 1'b1, 14'h2ABC, 14'h0155);
        expectBeat(14'h2ABC, 14'h0155, 0, 0);
        applyStimulus(1'b0, 1'b0, 14'h0, 14'h0);
        checkOutput("restart_err", err, ERR_ON);
        checkOutput("narrow_do_en", n_do_en, 1);
        checkOutput("narrow_do_re", n_do_re, 10'h2AB);
        checkOutput("narrow_do_im", n_do_im, 10'h015);

        // Async reset between edges with a beat still in flight.
        applyStimulus(1'b0, 1'b1, 14'h0123, 14'h0456);
        expectBeat(14'h0123, 14'h0456, 1, 0);
        applyStimulus(1'b0, 1'b1, 14'h0222, 14'h0333);
        @(negedge clk);
        #1;
        di_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("async_do_en", do_en, 0);
        checkOutput("async_do_re", do_re, 0);
        checkOutput("async_do_im", do_im, 0);
        checkOutput("async_bin_idx", bin_idx, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_err", err, 0);
        @(posedge clk);
        #1;
        checkOutput("lost_beat_do_en", do_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("post_reset_busy", busy, 0);
        checkOutput("queue_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
